// File: rtl/counter_bus_pkg.sv
// counter_bus_pkg: bus widths and FSM state type shared by the counter bus master, the peripheral side and the bench
package counter_bus_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;
endpackage

// File: rtl/bus_timeout_timer.sv
// bus_timeout_timer: saturating wait counter; expired flags the cycle on which the count reaches TIMEOUT_CYCLES (0 = never)
module bus_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && TIMEOUT_CYCLES != 0 && cnt != W'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
  // Asserted one count early so the FSM leaves BUS on the edge where the count becomes TIMEOUT_CYCLES
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/counter_bus_master.sv
// counter_bus_master: single-outstanding register bus initiator with ack timeout and valid/ready command/response ports
module counter_bus_master
  import counter_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_wr,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_wr,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_bus_select,
  output logic              o_bus_wr,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_ack,
  output logic              o_stray_ack
);
  state_t state, state_d;
  logic expired, accept, done;
  assign o_cmd_ready = state == IDLE;
  assign accept = o_cmd_ready && i_cmd_valid;
  assign done = state == BUS && (i_bus_ack || expired);
  bus_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(i_sysclk),
    .rst_n(i_sysrst),
    .clear(accept),
    .enable(state == BUS),
    .expired(expired)
  );
  always_ff @(posedge i_sysclk or negedge i_sysrst)
    if (!i_sysrst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (i_cmd_valid ? BUS : IDLE)
            : state == BUS  ? (done ? RSP : BUS)
            : (i_rsp_ready ? IDLE : RSP);
  end
  always_ff @(posedge i_sysclk or negedge i_sysrst)
    if (!i_sysrst) begin
      o_bus_select <= 1'b0;
      o_bus_wr     <= 1'b0;
      o_reg_addr   <= '0;
      o_bus_data   <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_wr     <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_err    <= 1'b0;
      o_stray_ack  <= 1'b0;
    end else begin
      o_stray_ack <= i_bus_ack && state != BUS;
      if (accept) begin
        o_bus_select <= 1'b1;
        o_bus_wr     <= i_cmd_wr;
        o_reg_addr   <= i_cmd_addr;
        o_bus_data   <= i_cmd_data;
      end
      // Ack takes priority over a same-cycle timeout
      if (done) begin
        o_bus_select <= 1'b0;
        o_bus_wr     <= 1'b0;
        o_rsp_valid  <= 1'b1;
        o_rsp_wr     <= o_bus_wr;
        o_rsp_data   <= (i_bus_ack && !o_bus_wr) ? i_bus_data : '0;
        o_rsp_err    <= !i_bus_ack;
      end
      if (state == RSP && i_rsp_ready) o_rsp_valid <= 1'b0;
    end
endmodule

// File: doc/counter_bus_master.md
# counter_bus_master

Bus initiator for the counter peripheral register bus. Accepts single register read/write commands over a valid/ready command port, drives the select/write/address/data bus into the counter peripheral, waits for its acknowledge (with timeout), and returns read data and status over a valid/ready response port. It sits between a CPU-side or test-sequencer command source and one counter peripheral instance.

## Interface
- TIMEOUT_CYCLES, 16: max bus cycles waited for ack; 0 = wait forever
- i_sysclk  in  1  system clock, all logic rising-edge
- i_sysrst  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  block can accept command
- i_cmd_wr  in  1  1 = write, 0 = read
- i_cmd_addr  in  4  register address
- i_cmd_data  in  16  write data (ignored for reads)
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer takes response
- o_rsp_wr  out  1  echo of command type
- o_rsp_data  out  16  read data; 0 for writes and errors
- o_rsp_err  out  1  1 = timeout, no ack
- o_bus_select  out  1  peripheral select
- o_bus_wr  out  1  bus write strobe
- o_reg_addr  out  4  bus address
- o_bus_data  out  16  bus write data
- i_bus_data  in  16  peripheral read data
- i_bus_ack  in  1  peripheral acknowledge
- o_stray_ack  out  1  one-cycle pulse: ack seen outside a transaction

## Operation
- FSM states: IDLE, BUS, RSP.
- IDLE: o_cmd_ready=1. On i_cmd_valid&o_cmd_ready: register wr/addr/data into bus outputs, set o_bus_select=1, clear wait counter, -> BUS.
- BUS: select, wr, addr, data held stable. Wait counter increments each cycle, saturating at TIMEOUT_CYCLES.
  - i_bus_ack=1: capture i_bus_data into o_rsp_data if read (else 0), o_rsp_err=0, -> RSP.
  - else counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0): o_rsp_data=0, o_rsp_err=1, -> RSP.
  - Ack and timeout on same cycle: ack wins, err=0.
- RSP: o_bus_select=0, o_bus_wr=0; o_rsp_valid=1 with stable wr/data/err until i_rsp_ready=1, then -> IDLE.
- o_reg_addr/o_bus_data hold last values when idle; o_bus_wr only high while o_bus_select high.
- i_bus_ack high in IDLE or RSP: ignored for data, o_stray_ack pulses next cycle.
- One outstanding transaction; no command accepted in BUS or RSP.

## Timing
- All outputs registered except o_cmd_ready (= state==IDLE).
- Reset (i_sysrst=0): state IDLE; o_bus_select, o_bus_wr, o_rsp_valid, o_rsp_err, o_stray_ack = 0; o_reg_addr, o_bus_data, o_rsp_data = 0; o_rsp_wr = 0. Applies immediately, including mid-BUS (select drops asynchronously; transaction lost, no response).
- Command accepted at edge E0 -> o_bus_select high from E0.
- Ack sampled high at edge E0+k (k≥1) -> o_bus_select low and o_rsp_valid high from E0+k.
- Timeout: ack low on edges E0+1..E0+TIMEOUT_CYCLES -> o_rsp_valid, o_rsp_err high from E0+TIMEOUT_CYCLES.
- Response consumed at edge E1 -> IDLE from E1; next command earliest accepted at E1+1, so select is low ≥2 cycles between transactions.
- Back-to-back throughput, ack at k=1 and rsp_ready held high: one transaction per 3 cycles.
- Wait counter width $clog2(TIMEOUT_CYCLES+1), min 1.

## Structure
- Package counter_bus_pkg: ADDR_W=4, DATA_W=16, FSM state enum {IDLE, BUS, RSP}; shared with the peripheral side and bench.
- Sub-module bus_timeout_timer: clear/enable/saturating counter with expired output, parameterised by TIMEOUT_CYCLES (0 = never expires).
- Top: FSM, bus output registers, response registers.

## Test plan
- Write addr 0x3, data 0xA5C3, ack after 2 cycles -> select high 2 cycles with wr=1, addr=0x3, data=0xA5C3; rsp_valid, rsp_wr=1, err=0, data=0x0000.
- Read addr 0x7, ack at k=1 with i_bus_data=0x1234 -> rsp_data=0x1234, err=0; select high exactly 1 cycle.
- Read, ack never, TIMEOUT_CYCLES=16 -> rsp_valid 16 cycles after accept, err=1, data=0x0000; ack at cycle 16 instead -> err=0.
- rsp_ready held low 5 cycles after response -> rsp fields stable, cmd_ready=0, second command stalls until consumed.
- Reset asserted mid-BUS -> select, rsp_valid drop immediately; after release, cmd_ready=1 and next read completes normally.
- Ack pulse while IDLE -> o_stray_ack one-cycle pulse, no response, state stays IDLE.
